// File: rtl/conv_via_tiling_pkg.sv
// Shared types and helpers for the conv_via_tiling tile-loop arbiters.
package conv_via_tiling_pkg;

   localparam int MUL_W   = 32;
   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   // Single response slot: owner index plus registered product.
   typedef struct packed {
      logic             full;
      logic [IDX_W-1:0] owner;
      logic [MUL_W-1:0] data;
   } slot_t;

   // One-hot grant for the first set bit of valid at or above ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [IDX_W-1:0]   ptr,
                                                  input int                 n = MAX_REQ);
      logic [MAX_REQ-1:0] gnt;
      logic               found;
      int                 idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= n) idx = idx - n;
         if (k < n && !found && valid[idx[IDX_W-1:0]]) begin
            gnt[idx[IDX_W-1:0]] = 1'b1;
            found               = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/conv_via_tiling_mul_32s_32s_32_1_1.sv
// Combinational 32x32 signed multiplier, low 32 bits of the product.
module conv_via_tiling_mul_32s_32s_32_1_1
   import conv_via_tiling_pkg::*;
(
   input  logic [MUL_W-1:0] din0,
   input  logic [MUL_W-1:0] din1,
   output logic [MUL_W-1:0] dout
);

   // Truncated signed product; wraps with no saturation.
   assign dout = MUL_W'($signed(din0) * $signed(din1));

endmodule

// File: rtl/conv_via_tiling_mul_arb.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters,
// returning each product through a single registered response slot.
module conv_via_tiling_mul_arb
   import conv_via_tiling_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = MUL_W
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]           rsp_data
);

   slot_t              slot;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   gidx;
   logic [IDX_W-1:0]   ptr_nxt;
   logic [MAX_REQ-1:0] pick;
   logic               drain;
   logic               can_accept;
   logic               accept;
   logic [DATA_W-1:0]  mul_a;
   logic [DATA_W-1:0]  mul_b;
   logic [DATA_W-1:0]  mul_p;

   assign pick = rr_pick(MAX_REQ'(req_valid), rr_ptr, NUM_REQ);

   // Decode slot owner into one-hot response valid and detect a drain.
   always_comb begin
      rsp_valid = '0;
      drain     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (slot.owner == IDX_W'(i)) begin
            rsp_valid[i] = slot.full;
            drain        = slot.full && rsp_ready[i];
         end
      end
   end

   // Grant selection; slot may be refilled in the same cycle it drains.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < MAX_REQ; i++)
         if (pick[i]) gidx = IDX_W'(i);
      can_accept = !slot.full || drain;
      accept     = (|pick) && can_accept && !ap_rst;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = accept && pick[i];
      ptr_nxt = (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
   end

   // Operand mux feeding the shared multiplier from the granted requester.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx == IDX_W'(i)) begin
            mul_a = req_a[i*DATA_W +: DATA_W];
            mul_b = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   conv_via_tiling_mul_32s_32s_32_1_1 u_mul (
      .din0 (mul_a),
      .din1 (mul_b),
      .dout (mul_p)
   );

   // Slot and priority pointer; pointer moves only on a grant.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         slot   <= '0;
         rr_ptr <= '0;
      end else if (accept) begin
         slot.full  <= 1'b1;
         slot.owner <= gidx;
         slot.data  <= mul_p;
         rr_ptr     <= ptr_nxt;
      end else if (drain) begin
         slot.full <= 1'b0;
      end
   end

   assign rsp_data = slot.data;

endmodule

// File: tb/tb_conv_via_tiling_mul_arb.sv
// Scoreboard bench for conv_via_tiling_mul_arb: driver models grants and
// pushes expected responses, monitor pops and compares at each negedge.
module tb_conv_via_tiling_mul_arb;

   localparam int N = 4;

   logic            ap_clk = 1'b0;
   logic            ap_rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a = '0;
   logic [N*32-1:0] req_b = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic [31:0]     rsp_data;

   conv_via_tiling_mul_arb #(.NUM_REQ(N), .DATA_W(32)) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int          owner;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int   glog[$];
   int   tests = 0;
   int   fails = 0;
   bit   started = 1'b0;
   bit   reissue = 1'b0;
   bit   acc_flag [N];

   // reference model state
   bit   m_full = 1'b0;
   int   m_owner = 0;
   int   m_ptr = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mulw(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[31:0];
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFFFFFF;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         default: return $urandom();
      endcase
   endfunction

   function automatic bit outstanding(input int i);
      foreach (sbq[k]) if (sbq[k].owner == i) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_valid[i]      = 1'b1;
      acc_flag[i]       = 1'b0;
   endtask

   // One clock: predict and check grant at negedge, update model after the edge.
   task automatic cycle();
      int           g;
      int           idx;
      bit           dr;
      logic [N-1:0] exp_rdy;
      logic [31:0]  p;
      @(negedge ap_clk);
      dr = m_full && rsp_ready[m_owner];
      g  = -1;
      if (!ap_rst && (!m_full || dr)) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      p = (g >= 0) ? mulw(req_a[g*32 +: 32], req_b[g*32 +: 32]) : 32'h0;
      @(posedge ap_clk);
      #1;
      if (ap_rst) begin
         m_full = 1'b0;
         m_ptr  = 0;
         sbq.delete();
      end else if (g >= 0) begin
         sbq.push_back('{owner: g, data: p});
         glog.push_back(g);
         m_full      = 1'b1;
         m_owner     = g;
         m_ptr       = (g + 1) % N;
         acc_flag[g] = 1'b1;
         if (reissue) begin
            req_a[g*32 +: 32] = rnd_op();
            req_b[g*32 +: 32] = rnd_op();
         end else begin
            req_valid[g] = 1'b0;
         end
      end else if (dr) begin
         m_full = 1'b0;
      end
   endtask

   task automatic issue_wait(input int i, input logic [31:0] a, input logic [31:0] b);
      load(i, a, b);
      for (int t = 0; t < 20 && !acc_flag[i]; t++) cycle();
      chk("grant_timeout", 32'(acc_flag[i]), 32'd1);
   endtask

   // Monitor: every presented response must match the scoreboard head.
   initial begin
      exp_t e;
      wait (started);
      forever begin
         @(negedge ap_clk);
         if (sbq.size() == 0) begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
         end else begin
            e = sbq[0];
            chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.owner);
            chk("rsp_data", rsp_data, e.data);
            if (rsp_ready[e.owner]) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] held;
      int          ow [2];
      ow[0] = 3;
      ow[1] = 1;

      // reset with everyone requesting, then strict rotation
      rsp_ready = '1;
      reissue   = 1'b1;
      for (int i = 0; i < N; i++) load(i, rnd_op(), rnd_op());
      ap_rst = 1'b1;
      cycle();
      started = 1'b1;
      cycle();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      ap_rst = 1'b0;
      glog.delete();
      repeat (6) cycle();
      chk("rot_count", glog.size(), 6);
      for (int k = 0; k < 6 && k < glog.size(); k++) chk("rot_order", glog[k], k % N);
      reissue   = 1'b0;
      req_valid = '0;
      repeat (2) cycle();

      // basic product and wrap cases
      issue_wait(1, -32'sd7, 32'sd6);
      chk("basic_valid", 32'(rsp_valid), 32'b0010);
      chk("basic_data", rsp_data, 32'hFFFFFFD6);
      cycle();
      issue_wait(0, 32'h40000000, 32'd4);
      chk("wrap0_data", rsp_data, 32'h0);
      cycle();
      issue_wait(2, 32'h7FFFFFFF, 32'h7FFFFFFF);
      chk("wrap1_data", rsp_data, 32'h1);
      cycle();

      // backpressure on requester 2, then same-cycle refill to 3 then 0
      rsp_ready = 4'b1011;
      issue_wait(2, 32'd12345, -32'sd3);
      held = rsp_data;
      load(0, 32'd11, 32'd13);
      load(3, -32'sd5, 32'd9);
      repeat (5) begin
         cycle();
         chk("bp_valid", 32'(rsp_valid), 32'b0100);
         chk("bp_data", rsp_data, held);
      end
      glog.delete();
      rsp_ready = '1;
      cycle();
      chk("bp_refill_cnt", glog.size(), 1);
      if (glog.size() > 0) chk("bp_refill_first", glog[0], 3);
      cycle();
      chk("bp_refill_cnt2", glog.size(), 2);
      if (glog.size() > 1) chk("bp_refill_second", glog[1], 0);
      repeat (2) cycle();

      // mid-operation reset with a held slot
      foreach (ow[k]) begin
         rsp_ready = '1;
         rsp_ready[ow[k]] = 1'b0;
         issue_wait(ow[k], 32'd77, 32'd3);
         chk("mid_valid", 32'(rsp_valid), 32'd1 << ow[k]);
         ap_rst = 1'b1;
         cycle();
         ap_rst = 1'b0;
         chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
         rsp_ready = '1;
         glog.delete();
         load(1, 32'd2, 32'd3);
         load(2, 32'd4, 32'd5);
         cycle();
         chk("mid_ptr_grant", glog.size() > 0 ? glog[0] : -1, 1);
         repeat (3) cycle();
      end

      // randomized traffic with random response backpressure
      repeat (400) begin
         rsp_ready = N'($urandom());
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && !outstanding(i) && $urandom_range(0, 2) == 0)
               load(i, rnd_op(), rnd_op());
         cycle();
      end
      rsp_ready = '1;
      repeat (20) cycle();
      chk("final_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
